bicubic_channel_sched: RTL
==========================

Name: bicubic_channel_sched

Overview:
- Time-multiplexes one 8-bit single-channel bicubic upsample core across the R, G and B channels of a 4x4 RGB source window.
- For each window it issues three core requests in order R, G, B and collects four response beats per request (one beat = one output row of 4 pixels).
- It then emits the 4x4 upsampled block as four RGB rows on a valid/ready stream.
- Sits between the line-buffer window fetcher and the output packer.

Parameters:
- CHANNEL_WIDTH, 8, bits per colour channel; must match the core.
- PIX_WIDTH, 3*CHANNEL_WIDTH, bits per RGB pixel as {R,G,B}, R in MSBs.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  source window valid
- in_ready  out  1  scheduler can accept a window
- in_win  in  16*PIX_WIDTH  pixel k (k=0..15, row-major, k=0 maps to core p1) at [PIX_WIDTH*k +: PIX_WIDTH]
- core_req_valid  out  1  request to core
- core_req_ready  in  1  core accepts request
- core_pix  out  16*CHANNEL_WIDTH  selected channel of pixel k at [CHANNEL_WIDTH*k +: CHANNEL_WIDTH]
- core_rsp_valid  in  1  core response beat valid
- core_rsp_ready  out  1  scheduler accepts beat
- core_rsp_data  in  4*CHANNEL_WIDTH  output pixel j (j=0..3) at [CHANNEL_WIDTH*j +: CHANNEL_WIDTH]
- out_valid  out  1  output row valid
- out_ready  in  1  downstream accepts row
- out_data  out  4*PIX_WIDTH  RGB pixel j of the current row at [PIX_WIDTH*j +: PIX_WIDTH]
- out_row  out  2  row index 0..3 of out_data
- out_last  out  1  high with row 3
- busy  out  1  state != IDLE

Behaviour:
- Clock, reset and storage:
  - Single clock domain.
  - rst_n is sampled on the rising clk edge. When low: state=IDLE, ch_cnt=0, row_cnt=0.
  - Window and result buffers have no reset.
- Reset output values (first edge with rst_n low): in_ready=1, core_req_valid=0, core_rsp_ready=0, out_valid=0, out_last=0, out_row=0, busy=0.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready: latch in_win, ch_cnt<=0, go to REQ.
  - REQ: core_req_valid=1. core_pix = channel ch_cnt of the latched window (0=R [23:16], 1=G [15:8], 2=B [7:0] for the default width). On core handshake: row_cnt<=0, go to COLLECT.
  - COLLECT: core_rsp_ready=1. Each beat handshake writes core_rsp_data into buf[ch_cnt][row_cnt] and increments row_cnt. On the 4th beat (row_cnt==3):
    - ch_cnt<2: ch_cnt++, go to REQ.
    - ch_cnt==2: row_cnt<=0, go to EMIT.
  - EMIT: out_valid=1, out_row=row_cnt, out_last=(row_cnt==3). out_data pixel j = {buf[0][row][j], buf[1][row][j], buf[2][row][j]}. On out handshake row_cnt++. On the row-3 handshake go to IDLE.
- No zero-wait-state bubbles beyond one registered state transition per phase:
  - core_req_valid rises the cycle after the window handshake and the cycle after each channel's 4th beat.
  - out_valid rises the cycle after B's 4th beat.
  - in_ready rises the cycle after the row-3 output handshake.
- Stalls:
  - core_pix is held stable while core_req_valid=1 and core_req_ready=0.
  - out_data, out_row and out_last are held stable while out_valid=1 and out_ready=0.
- Protocol rules:
  - core_rsp_valid outside COLLECT is ignored; core_rsp_ready stays 0 there.
  - core_req_ready outside REQ is ignored.
- Only one window is in flight. in_ready=0 from window acceptance until the final output handshake.
- Control-path-only module with no arithmetic. Widths pass through unchanged.
- Reset mid-operation: any state returns to IDLE on the next edge and partial results are discarded. The core shares rst_n and resets together with the scheduler.

Test Plan:
- Beat model used throughout: the core accepts requests immediately and returns channel c, row r, byte j = 16*c+4*r+j, with rsp 2 cycles after the request and beats back-to-back. Expected row r, pixel j = {4r+j, 0x10+4r+j, 0x20+4r+j}.
- Single window, out_ready=1 -> core_req_valid seen exactly 3 times. core_pix on the R request = R bytes of in_win pixels 0..15. Rows out in order 0..3 with out_last only on row 3. Row 2 pixel 1 = 0x091929. in_ready returns 1 the cycle after row 3.
- Backpressure: core_req_ready held 0 for 5 cycles on the G request, and out_ready toggled 1/0 every cycle -> core_pix and out_data stable while stalled, same data as the previous test, no lost or duplicated rows.
- Spurious traffic: core_rsp_valid pulsed in IDLE and EMIT -> core_rsp_ready=0, buffers unchanged, outputs match the expected values.
- in_valid held high continuously with 3 different windows -> in_ready=1 only in IDLE. Exactly 12 output rows, per-window data correct, no overlap between windows.
- Reset asserted during COLLECT of G after 2 beats -> next edge all valids 0, in_ready=1, busy=0. A fresh window afterwards produces correct output.

Source files
------------

// File: rtl/bicubic_channel_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : bicubic_channel_sched
// Purpose  : Time-multiplexes one single-channel bicubic upsample core over
//            the R, G and B planes of a 4x4 RGB window, collects four row
//            beats per channel and emits the upsampled 4x4 block as four RGB
//            rows on a valid/ready stream.
// Revision : 1.0 - initial release
// ============================================================================
module bicubic_channel_sched #(
  parameter int CHANNEL_WIDTH = 8,
  parameter int PIX_WIDTH     = 3*CHANNEL_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [16*PIX_WIDTH-1:0]    in_win,
  output logic                       core_req_valid,
  input  logic                       core_req_ready,
  output logic [16*CHANNEL_WIDTH-1:0] core_pix,
  input  logic                       core_rsp_valid,
  output logic                       core_rsp_ready,
  input  logic [4*CHANNEL_WIDTH-1:0] core_rsp_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [4*PIX_WIDTH-1:0]     out_data,
  output logic [1:0]                 out_row,
  output logic                       out_last,
  output logic                       busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_COLLECT = 2'd2,
    S_EMIT    = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic [1:0] r_ch_cnt;
  logic [1:0] w_ch_cnt_nxt;
  logic [1:0] r_row_cnt;
  logic [1:0] w_row_cnt_nxt;
  logic w_win_load;
  logic w_buf_wr;

  // Latched source window and per-channel result rows; data only, no reset.
  logic [16*PIX_WIDTH-1:0]   r_win;
  logic [4*CHANNEL_WIDTH-1:0] r_buf [3][4];

  // Control state and counters; reset discards any partial block.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_ch_cnt  <= 2'd0;
      r_row_cnt <= 2'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_ch_cnt  <= w_ch_cnt_nxt;
      r_row_cnt <= w_row_cnt_nxt;
    end
  end

  // Window capture on acceptance and result beat capture on each core beat.
  always_ff @(posedge clk) begin
    if (w_win_load) begin
      r_win <= in_win;
    end
    if (w_buf_wr) begin
      r_buf[r_ch_cnt][r_row_cnt] <= core_rsp_data;
    end
  end

  // Next-state, counter updates and handshake strobes for the four phases.
  always_comb begin
    w_state_nxt    = r_state;
    w_ch_cnt_nxt   = r_ch_cnt;
    w_row_cnt_nxt  = r_row_cnt;
    w_win_load     = 1'b0;
    w_buf_wr       = 1'b0;
    in_ready       = 1'b0;
    core_req_valid = 1'b0;
    core_rsp_ready = 1'b0;
    out_valid      = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_win_load   = 1'b1;
          w_ch_cnt_nxt = 2'd0;
          w_state_nxt  = S_REQ;
        end
      end
      S_REQ: begin
        core_req_valid = 1'b1;
        if (core_req_ready) begin
          w_row_cnt_nxt = 2'd0;
          w_state_nxt   = S_COLLECT;
        end
      end
      S_COLLECT: begin
        core_rsp_ready = 1'b1;
        if (core_rsp_valid) begin
          w_buf_wr      = 1'b1;
          w_row_cnt_nxt = r_row_cnt + 2'd1;
          if (r_row_cnt == 2'd3) begin
            if (r_ch_cnt == 2'd2) begin
              w_row_cnt_nxt = 2'd0;
              w_state_nxt   = S_EMIT;
            end else begin
              w_ch_cnt_nxt = r_ch_cnt + 2'd1;
              w_state_nxt  = S_REQ;
            end
          end
        end
      end
      S_EMIT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_row_cnt_nxt = r_row_cnt + 2'd1;
          if (r_row_cnt == 2'd3) begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign busy     = (r_state != S_IDLE);
  assign out_row  = (r_state == S_EMIT) ? r_row_cnt : 2'd0;
  assign out_last = (r_state == S_EMIT) && (r_row_cnt == 2'd3);

  // Channel slice of each latched pixel; R sits in the pixel MSBs.
  generate
    for (genvar k = 0; k < 16; k++) begin : g_pix
      assign core_pix[CHANNEL_WIDTH*k +: CHANNEL_WIDTH] =
        (r_ch_cnt == 2'd0) ? r_win[PIX_WIDTH*k + 2*CHANNEL_WIDTH +: CHANNEL_WIDTH] :
        (r_ch_cnt == 2'd1) ? r_win[PIX_WIDTH*k +   CHANNEL_WIDTH +: CHANNEL_WIDTH] :
                             r_win[PIX_WIDTH*k                   +: CHANNEL_WIDTH];
    end
  endgenerate

  // Re-interleave the three channel planes of the current row into RGB pixels.
  generate
    for (genvar j = 0; j < 4; j++) begin : g_out
      assign out_data[PIX_WIDTH*j +: PIX_WIDTH] = {
        r_buf[0][r_row_cnt][CHANNEL_WIDTH*j +: CHANNEL_WIDTH],
        r_buf[1][r_row_cnt][CHANNEL_WIDTH*j +: CHANNEL_WIDTH],
        r_buf[2][r_row_cnt][CHANNEL_WIDTH*j +: CHANNEL_WIDTH]
      };
    end
  endgenerate

endmodule
`default_nettype wire
